// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width encodings,
// FSM states and fault causes.
package lsu_pkg;

  // RV32I funct3 width/sign encodings for loads and stores
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_RESP = 2'd2,
    S_DONE = 2'd3
  } lsu_state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE       = 2'd0,
    CAUSE_MISALIGNED = 2'd1,
    CAUSE_ILLEGAL    = 2'd2,
    CAUSE_TIMEOUT    = 2'd3
  } fault_cause_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational datapath of the load/store unit: store lane steering and
// byte strobes, request legality/alignment check, and load extract/extend.
module lsu_align
  import lsu_pkg::*;
(
  input  logic         req_is_store,
  input  logic [2:0]   req_funct3,
  input  logic [1:0]   req_offset,
  input  logic [31:0]  req_wdata,
  output logic [3:0]   wstrb,
  output logic [31:0]  wdata_lane,
  output fault_cause_t check_cause,
  input  logic [2:0]   rsp_funct3,
  input  logic [1:0]   rsp_offset,
  input  logic [31:0]  rdata,
  output logic [31:0]  load_value
);

  logic        illegal;
  logic        misaligned;
  logic [31:0] shifted;

  // Store strobes and replicated write data; loads drive no strobes
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    wstrb      = 4'b0000;
    wdata_lane = 32'h0;
    if (req_is_store) begin
      case (req_funct3)
        F3_B: begin
          wstrb      = 4'b0001 << req_offset;
          wdata_lane = {4{req_wdata[7:0]}};
        end
        F3_H: begin
          wstrb      = 4'b0011 << req_offset;
          wdata_lane = {2{req_wdata[15:0]}};
        end
        F3_W: begin
          wstrb      = 4'b1111;
          wdata_lane = req_wdata;
        end
        default: begin
          wstrb      = 4'b0000;
          wdata_lane = 32'h0;
        end
      endcase
    end
  end

  // Legality and alignment check; an illegal funct3 outranks misalignment
  always_comb begin
    if (req_is_store) illegal = (req_funct3 > F3_W);
    else              illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
    misaligned = ((req_funct3[1:0] == 2'b01) && req_offset[0]) ||
                 ((req_funct3[1:0] == 2'b10) && (req_offset != 2'b00));
    if (illegal)         check_cause = CAUSE_ILLEGAL;
    else if (misaligned) check_cause = CAUSE_MISALIGNED;
    else                 check_cause = CAUSE_NONE;
  end

  // Load extract: bring the addressed byte/half to bit 0, then extend
  always_comb begin
    shifted = rdata >> {rsp_offset, 3'b000};
    case (rsp_funct3)
      F3_B:    load_value = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    load_value = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   load_value = {24'h0, shifted[7:0]};
      F3_HU:   load_value = {16'h0, shifted[15:0]};
      default: load_value = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: turns one RV32I load/store into a request/response
// transaction on the data-memory bus, stalls the core while it is pending,
// and returns extended load data or a fault with a one-cycle done pulse.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  // One extra bit so the incremented count can never wrap below the limit
  localparam logic [16:0] TIMEOUT_LIMIT = 17'(TIMEOUT_CYCLES);

  lsu_state_t   state;
  logic [15:0]  tmo_cnt;
  logic [16:0]  tmo_next;
  logic         op_is_store;
  logic [2:0]   op_funct3;
  logic [1:0]   op_offset;

  logic [3:0]   lane_wstrb;
  logic [31:0]  lane_wdata;
  fault_cause_t check_cause;
  logic [31:0]  load_value;

  lsu_align u_align (
    .req_is_store (req_is_store),
    .req_funct3   (req_funct3),
    .req_offset   (req_addr[1:0]),
    .req_wdata    (req_wdata),
    .wstrb        (lane_wstrb),
    .wdata_lane   (lane_wdata),
    .check_cause  (check_cause),
    .rsp_funct3   (op_funct3),
    .rsp_offset   (op_offset),
    .rdata        (mem_rdata),
    .load_value   (load_value)
  );

  assign tmo_next = {1'b0, tmo_cnt} + 17'd1;
  assign busy     = (req_valid && (state == S_IDLE)) || (state == S_ADDR) || (state == S_RESP);

  // Access FSM with timeout counter and all registered outputs
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state       <= S_IDLE;
      tmo_cnt     <= '0;
      op_is_store <= 1'b0;
      op_funct3   <= '0;
      op_offset   <= '0;
      done        <= 1'b0;
      fault       <= 1'b0;
      fault_cause <= CAUSE_NONE;
      load_data   <= '0;
      mem_valid   <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wstrb   <= '0;
      mem_wdata   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          tmo_cnt <= '0;
          if (req_valid) begin
            if (check_cause != CAUSE_NONE) begin
              // Rejected before any bus activity
              fault       <= 1'b1;
              fault_cause <= check_cause;
              if (!req_is_store) load_data <= '0;
              done        <= 1'b1;
              state       <= S_DONE;
            end else begin
              op_is_store <= req_is_store;
              op_funct3   <= req_funct3;
              op_offset   <= req_addr[1:0];
              mem_valid   <= 1'b1;
              mem_we      <= req_is_store;
              mem_addr    <= {req_addr[31:2], 2'b00};
              mem_wstrb   <= lane_wstrb;
              mem_wdata   <= lane_wdata;
              state       <= S_ADDR;
            end
          end
        end

        S_ADDR: begin
          tmo_cnt <= tmo_next[15:0];
          if (mem_ready) begin
            mem_valid <= 1'b0;
            state     <= S_RESP;
          end else if (tmo_next >= TIMEOUT_LIMIT) begin
            mem_valid   <= 1'b0;
            fault       <= 1'b1;
            fault_cause <= CAUSE_TIMEOUT;
            if (!op_is_store) load_data <= '0;
            done        <= 1'b1;
            state       <= S_DONE;
          end
        end

        S_RESP: begin
          tmo_cnt <= tmo_next[15:0];
          if (mem_rvalid) begin
            if (!op_is_store) load_data <= load_value;
            done  <= 1'b1;
            state <= S_DONE;
          end else if (tmo_next >= TIMEOUT_LIMIT) begin
            fault       <= 1'b1;
            fault_cause <= CAUSE_TIMEOUT;
            if (!op_is_store) load_data <= '0;
            done        <= 1'b1;
            state       <= S_DONE;
          end
        end

        S_DONE: begin
          done        <= 1'b0;
          fault       <= 1'b0;
          fault_cause <= CAUSE_NONE;
          state       <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: stimulus pushes expected bus
// requests and completions into queues; negedge monitors pop and compare.
module tb_load_store_unit;
  import lsu_pkg::*;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } bus_t;

  typedef struct {
    logic [31:0] ld;
    logic        flt;
    logic [1:0]  cause;
  } rsp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_valid2 = 1'b0;
  logic        req_is_store = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        mem_ready = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  logic        busy, done, fault, mem_valid, mem_we;
  logic [31:0] load_data, mem_addr, mem_wdata;
  logic [1:0]  fault_cause;
  logic [3:0]  mem_wstrb;

  logic        busy2, done2, fault2, mem_valid2, mem_we2;
  logic [31:0] load_data2, mem_addr2, mem_wdata2;
  logic [1:0]  fault_cause2;
  logic [3:0]  mem_wstrb2;

  bus_t exp_bus[$];
  rsp_t exp_rsp[$];
  rsp_t exp_rsp2[$];

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .busy(busy), .done(done), .load_data(load_data), .fault(fault),
    .fault_cause(fault_cause), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  // Second instance with a short timeout; shares all inputs except req_valid
  load_store_unit #(.TIMEOUT_CYCLES(4)) dut_tmo (
    .clk(clk), .reset(reset), .req_valid(req_valid2), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .busy(busy2), .done(done2), .load_data(load_data2), .fault(fault2),
    .fault_cause(fault_cause2), .mem_valid(mem_valid2), .mem_ready(mem_ready),
    .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wstrb(mem_wstrb2),
    .mem_wdata(mem_wdata2), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Bus monitor: while a request is up it must match the head of the queue
  always @(negedge clk) begin
    bus_t eb;
    if (mem_valid) begin
      if (exp_bus.size() == 0) begin
        check("unexpected mem_valid", 32'd1, 32'd0);
      end else begin
        eb = exp_bus[0];
        check("mem_we",    {31'h0, mem_we}, {31'h0, eb.we});
        check("mem_addr",  mem_addr, eb.addr);
        check("mem_wstrb", {28'h0, mem_wstrb}, {28'h0, eb.strb});
        check("mem_wdata", mem_wdata, eb.wdata);
        if (mem_ready) void'(exp_bus.pop_front());
      end
    end
  end

  // Completion monitors for both instances
  always @(negedge clk) begin
    rsp_t er;
    if (done) begin
      if (exp_rsp.size() == 0) begin
        check("unexpected done", 32'd1, 32'd0);
      end else begin
        er = exp_rsp.pop_front();
        check("load_data",   load_data, er.ld);
        check("fault",       {31'h0, fault}, {31'h0, er.flt});
        check("fault_cause", {30'h0, fault_cause}, {30'h0, er.cause});
      end
    end
    if (done2) begin
      if (exp_rsp2.size() == 0) begin
        check("unexpected done (tmo dut)", 32'd1, 32'd0);
      end else begin
        er = exp_rsp2.pop_front();
        check("tmo load_data",   load_data2, er.ld);
        check("tmo fault",       {31'h0, fault2}, {31'h0, er.flt});
        check("tmo fault_cause", {30'h0, fault_cause2}, {30'h0, er.cause});
      end
    end
  end

  // Issue one op on the main instance and play the bus for it
  task automatic run_op(input string name, input logic st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int ready_wait, input logic [31:0] rdata,
                        input int exp_lat, input bit has_bus,
                        input bus_t eb, input rsp_t er);
    int  waited = 0;
    bit  hs = 1'b0;
    bit  busy_ok = 1'b1;
    int  lat = -1;
    if (has_bus) exp_bus.push_back(eb);
    exp_rsp.push_back(er);
    @(posedge clk); #1;
    req_is_store = st; req_funct3 = f3; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    #1 if (!busy) busy_ok = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      mem_rvalid = hs;
      mem_rdata  = hs ? rdata : 32'h5A5A5A5A;
      hs = 1'b0;
      if (done) begin
        lat = c;
        req_valid = 1'b0;
        mem_ready = 1'b0;
        break;
      end
      if (!busy) busy_ok = 1'b0;
      if (mem_valid && waited == ready_wait) begin
        mem_ready = 1'b1;
        hs = 1'b1;
      end else begin
        mem_ready = 1'b0;
        if (mem_valid) waited++;
      end
    end
    if (lat < 0) begin
      req_valid = 1'b0;
      mem_ready = 1'b0;
    end
    check({name, " latency"}, 32'(lat), 32'(exp_lat));
    check({name, " busy until done"}, {31'h0, busy_ok}, 32'd1);
    @(negedge clk);
    check({name, " busy in done"}, {31'h0, busy}, 32'd0);
  endtask

  initial begin
    int  nvalid;
    int  lat;
    bit  quiet;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst done",        {31'h0, done}, 32'd0);
    check("rst fault",       {31'h0, fault}, 32'd0);
    check("rst fault_cause", {30'h0, fault_cause}, 32'd0);
    check("rst load_data",   load_data, 32'h0);
    check("rst mem_valid",   {31'h0, mem_valid}, 32'd0);
    check("rst mem_we",      {31'h0, mem_we}, 32'd0);
    check("rst mem_addr",    mem_addr, 32'h0);
    check("rst mem_wstrb",   {28'h0, mem_wstrb}, 32'd0);
    check("rst mem_wdata",   mem_wdata, 32'h0);
    check("rst busy",        {31'h0, busy}, 32'd0);
    reset = 1'b0;

    // Stores and loads, best case and with a stalled bus
    run_op("sb", 1'b1, F3_B, 32'h103, 32'h000000AB, 0, 32'h0, 3, 1'b1,
           '{1'b1, 32'h100, 4'b1000, 32'hABABABAB}, '{32'h0, 1'b0, 2'd0});
    run_op("lh", 1'b0, F3_H, 32'h102, 32'h0, 0, 32'h80011234, 3, 1'b1,
           '{1'b0, 32'h100, 4'b0000, 32'h0}, '{32'hFFFF8001, 1'b0, 2'd0});
    run_op("lhu", 1'b0, F3_HU, 32'h102, 32'h0, 0, 32'h80011234, 3, 1'b1,
           '{1'b0, 32'h100, 4'b0000, 32'h0}, '{32'h00008001, 1'b0, 2'd0});
    run_op("lbu", 1'b0, F3_BU, 32'h101, 32'h0, 0, 32'h80011234, 3, 1'b1,
           '{1'b0, 32'h100, 4'b0000, 32'h0}, '{32'h00000012, 1'b0, 2'd0});
    run_op("lb", 1'b0, F3_B, 32'h200, 32'h0, 0, 32'h000000F0, 3, 1'b1,
           '{1'b0, 32'h200, 4'b0000, 32'h0}, '{32'hFFFFFFF0, 1'b0, 2'd0});
    run_op("sh stall", 1'b1, F3_H, 32'h102, 32'h1234BEEF, 3, 32'h0, 6, 1'b1,
           '{1'b1, 32'h100, 4'b1100, 32'hBEEFBEEF}, '{32'hFFFFFFF0, 1'b0, 2'd0});
    run_op("sw", 1'b1, F3_W, 32'h20, 32'hDEADBEEF, 0, 32'h0, 3, 1'b1,
           '{1'b1, 32'h20, 4'b1111, 32'hDEADBEEF}, '{32'hFFFFFFF0, 1'b0, 2'd0});
    run_op("lw", 1'b0, F3_W, 32'h44, 32'h0, 1, 32'h13579BDF, 4, 1'b1,
           '{1'b0, 32'h44, 4'b0000, 32'h0}, '{32'h13579BDF, 1'b0, 2'd0});

    // Rejected requests: no bus activity, done next cycle
    run_op("lw misaligned", 1'b0, F3_W, 32'h002, 32'h0, 0, 32'h0, 1, 1'b0,
           '{1'b0, 32'h0, 4'b0, 32'h0}, '{32'h0, 1'b1, 2'd1});
    run_op("load f3=011", 1'b0, 3'b011, 32'h0, 32'h0, 0, 32'h0, 1, 1'b0,
           '{1'b0, 32'h0, 4'b0, 32'h0}, '{32'h0, 1'b1, 2'd2});
    run_op("lh misaligned", 1'b0, F3_H, 32'h101, 32'h0, 0, 32'h0, 1, 1'b0,
           '{1'b0, 32'h0, 4'b0, 32'h0}, '{32'h0, 1'b1, 2'd1});
    run_op("store f3=101 odd", 1'b1, F3_HU, 32'h101, 32'h0, 0, 32'h0, 1, 1'b0,
           '{1'b0, 32'h0, 4'b0, 32'h0}, '{32'h0, 1'b1, 2'd2});

    // Reset while waiting for the response
    exp_bus.push_back('{1'b0, 32'h20, 4'b0000, 32'h0});
    @(posedge clk); #1;
    req_is_store = 1'b0; req_funct3 = F3_W; req_addr = 32'h20; req_valid = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0; req_valid = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    check("rst-in-resp mem_valid", {31'h0, mem_valid}, 32'd0);
    check("rst-in-resp done",      {31'h0, done}, 32'd0);
    check("rst-in-resp busy",      {31'h0, busy}, 32'd0);
    reset = 1'b0;
    run_op("lw after reset", 1'b0, F3_W, 32'h10, 32'h0, 0, 32'hCAFEF00D, 3, 1'b1,
           '{1'b0, 32'h10, 4'b0000, 32'h0}, '{32'hCAFEF00D, 1'b0, 2'd0});

    // Timeout on the short-timeout instance; the bus never accepts
    exp_rsp2.push_back('{32'h0, 1'b1, 2'd3});
    @(posedge clk); #1;
    req_is_store = 1'b0; req_funct3 = F3_W; req_addr = 32'h40; req_valid2 = 1'b1;
    mem_ready = 1'b0;
    nvalid = 0;
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (done2) begin
        lat = c;
        break;
      end
      if (mem_valid2) nvalid++;
    end
    req_valid2 = 1'b0;
    check("tmo mem_valid cycles", 32'(nvalid), 32'd4);
    check("tmo latency", 32'(lat), 32'd5);
    @(posedge clk); #1;
    check("tmo mem_valid after", {31'h0, mem_valid2}, 32'd0);

    // Stray response while both instances are idle must be ignored
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hFFFFFFFF;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    quiet = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (done2 || busy2 || done || busy) quiet = 1'b0;
    end
    check("stray rvalid ignored", {31'h0, quiet}, 32'd1);
    check("tmo load_data held", load_data2, 32'h0);
    check("main load_data held", load_data, 32'hCAFEF00D);

    check("bus queue drained",  32'(exp_bus.size()), 32'd0);
    check("rsp queue drained",  32'(exp_rsp.size()), 32'd0);
    check("rsp2 queue drained", 32'(exp_rsp2.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage directly downstream of the ALU.
- The ALU's sum of rs1 and the immediate is the effective address; the unit turns each RV32I load or store into one request/response transaction on a simple data-memory bus.
- While an access is pending it asserts busy so the core holds the PC and register write-back.
- It returns load data, sign- or zero-extended, to the write-back mux.

Parameters:
TIMEOUT_CYCLES, 255, cycles allowed in ADDR+RESP before the access is abandoned with a timeout fault (range 1..65535)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high
req_valid  in  1  core presents a memory op; held until done
req_is_store  in  1  1=store, 0=load
req_funct3  in  3  RV32I width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU (stores: 000/001/010 only)
req_addr  in  32  effective byte address from ALU
req_wdata  in  32  rs2 value for stores
busy  out  1  stall request to core (combinational)
done  out  1  one-cycle completion pulse
load_data  out  32  extended load result, valid with done
fault  out  1  access faulted, valid with done
fault_cause  out  2  0 none, 1 misaligned, 2 illegal funct3, 3 timeout
mem_valid  out  1  bus request valid
mem_ready  in  1  bus accepts request when mem_valid & mem_ready
mem_we  out  1  write request
mem_addr  out  32  word-aligned address (req_addr with [1:0]=0)
mem_wstrb  out  4  byte enables (0 for loads)
mem_wdata  out  32  lane-shifted store data
mem_rvalid  in  1  response/ack, one cycle, for loads and stores
mem_rdata  in  32  read word, valid with mem_rvalid

Behaviour:
- Reset (sync, active-high): state=IDLE, timeout counter=0. All registered outputs are 0: done, fault, fault_cause, load_data, mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata.
- Reset mid-access abandons the access; mem_valid is 0 from the next cycle. The bus is responsible for dropping the orphaned response.
- FSM states: IDLE, ADDR, RESP, DONE.
- IDLE, req_valid=1, check fails:
  - misaligned (H with addr[0]=1, W with addr[1:0]!=0) -> fault_cause 1;
  - illegal funct3 (loads 011/110/111, stores anything above 010) -> fault_cause 2;
  - no bus activity; go to DONE.
  - If both apply, illegal funct3 takes priority.
- IDLE, req_valid=1, check passes:
  - latch mem_we, mem_addr, mem_wstrb, mem_wdata, funct3, addr[1:0];
  - mem_valid=1; go to ADDR.
- ADDR:
  - mem_valid and all request outputs stay stable until mem_ready.
  - On handshake: mem_valid=0, go to RESP.
- RESP:
  - on mem_rvalid: loads latch extended data into load_data; stores ignore mem_rdata; go to DONE.
  - mem_rvalid outside RESP is ignored.
- Timeout:
  - the counter increments each cycle in ADDR or RESP;
  - when it equals TIMEOUT_CYCLES, mem_valid=0, fault=1, cause 3, go to DONE;
  - the counter clears in IDLE.
- DONE: done=1 for exactly one cycle; fault/fault_cause/load_data are valid during it; then IDLE.
  - load_data holds its value until the next load completes; it is 0 on a faulted load.
- busy = req_valid & (state==IDLE) | (state==ADDR) | (state==RESP). busy is 0 in DONE so the core advances that cycle.
- Best-case latency: request accepted cycle 0; mem_ready=1 in cycle 1; rvalid in cycle 2; done in cycle 3.
- Store lanes:
  - B: wstrb = 0001 << addr[1:0], wdata = {4{byte}};
  - H: wstrb = 0011 << addr[1:0], wdata = {2{half}};
  - W: wstrb = 1111.
- Load extract:
  - word >> (8*addr[1:0]); low byte/half kept;
  - bit 7/15 replicated for B/H, zero-filled for BU/HU.
- A req_valid that remains high in the cycle after DONE is a new request.

Decomposition:
- Package lsu_pkg: funct3 width constants (F3_B, F3_H, F3_W, F3_BU, F3_HU), state enum, fault_cause enum.
- One combinational sub-module, lsu_align:
  - store side: store lane shift and strobe generation;
  - load side: load extract/extend and the alignment/legality check.
- FSM, timeout counter and registers stay in load_store_unit.

Test Plan:
- sb, addr 0x103, wdata 0x000000AB, ready immediately, rvalid next cycle -> mem_addr 0x100, mem_wstrb 1000, mem_wdata 0xABABABAB, mem_we=1; done at cycle 3, fault=0.
- lh, addr 0x102, rdata 0x80011234 -> load_data 0xFFFF8001. lhu same -> 0x00008001. lbu, addr 0x101 -> 0x00000012.
- lw, addr 0x002 -> mem_valid never asserts, done next cycle, fault=1, cause 1. funct3 011 load -> cause 2.
- mem_ready held low 3 cycles -> mem_valid/addr/strb/wdata stable throughout; busy=1 until done; done lands 3 cycles later than the best case.
- TIMEOUT_CYCLES=4, never ready -> mem_valid drops, done with cause 3 after 4 cycles in ADDR. A later stray mem_rvalid in IDLE is ignored.
- reset asserted while in RESP -> next cycle mem_valid=0, done=0, state IDLE. A following lw to 0x10 completes normally.
